// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares the chipset RAM port between system-bus memory
// cycles and the video fetcher. Each access runs as a request/done handshake
// toward the RAM. Bus cycles are held with memory_access_ready until their
// data has been returned. Video wins contention for a bounded streak of
// grants, and then the waiting bus cycle is served.
module ram_access_arbiter #(
    parameter int unsigned MAX_VIDEO_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [19:0] address,
    input  logic [7:0]  internal_data_bus,
    input  logic        memory_read_n,
    input  logic        memory_write_n,
    input  logic        ram_address_select_n,
    output logic        memory_access_ready,
    output logic [7:0]  bus_data_out,
    input  logic        video_request,
    input  logic [19:0] video_address,
    output logic        video_acknowledge,
    output logic [7:0]  video_data,
    output logic [19:0] ram_address,
    output logic [7:0]  ram_write_data,
    output logic        ram_read,
    output logic        ram_write,
    input  logic        ram_done,
    input  logic [7:0]  ram_read_data
);

    localparam int unsigned STREAK_W = $clog2(MAX_VIDEO_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VIDEO_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        BUS_ACCESS,
        VIDEO_ACCESS
    } state_t;

    state_t              r_state;
    logic [STREAK_W-1:0] r_streak;
    logic                r_bus_served;
    logic [19:0]         r_ram_address;
    logic [7:0]          r_ram_write_data;
    logic                r_ram_read;
    logic                r_ram_write;
    logic [7:0]          r_bus_data_out;
    logic [7:0]          r_video_data;
    logic                r_video_ack;

    logic w_bus_req;
    logic w_bus_pending;
    logic w_grant_video;
    logic w_grant_bus;

    assign w_bus_req     = ~ram_address_select_n & (~memory_read_n | ~memory_write_n);
    // bus_served keeps a completed cycle from being re-run while its strobe stays low
    assign w_bus_pending = w_bus_req & ~r_bus_served;

    assign memory_access_ready = ~w_bus_pending;
    assign bus_data_out        = r_bus_data_out;
    assign video_acknowledge   = r_video_ack;
    assign video_data          = r_video_data;
    assign ram_address         = r_ram_address;
    assign ram_write_data      = r_ram_write_data;
    assign ram_read            = r_ram_read;
    assign ram_write           = r_ram_write;

    // Arbitration in IDLE: video first unless its streak has used up the bus's patience
    always_comb begin
        w_grant_video = 1'b0;
        w_grant_bus   = 1'b0;
        if (r_state == IDLE) begin
            if (video_request && (!w_bus_pending || (r_streak < STREAK_MAX))) begin
                w_grant_video = 1'b1;
            end else if (w_bus_pending) begin
                w_grant_bus = 1'b1;
            end
        end
    end

    // Access sequencer: grant, hold the RAM request until done, then return data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_streak         <= '0;
            r_bus_served     <= 1'b0;
            r_ram_address    <= '0;
            r_ram_write_data <= '0;
            r_ram_read       <= 1'b0;
            r_ram_write      <= 1'b0;
            r_bus_data_out   <= '0;
            r_video_data     <= '0;
            r_video_ack      <= 1'b0;
        end else begin
            r_video_ack <= 1'b0;
            if (!w_bus_req) begin
                r_bus_served <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_grant_video) begin
                        r_state       <= VIDEO_ACCESS;
                        r_ram_address <= video_address;
                        r_ram_read    <= 1'b1;
                        r_ram_write   <= 1'b0;
                        if (w_bus_pending) begin
                            if (r_streak < STREAK_MAX) begin
                                r_streak <= r_streak + 1'b1;
                            end
                        end else begin
                            r_streak <= '0;
                        end
                    end else if (w_grant_bus) begin
                        r_state          <= BUS_ACCESS;
                        r_ram_address    <= address;
                        r_ram_write_data <= internal_data_bus;
                        r_ram_write      <= ~memory_write_n;
                        r_ram_read       <= memory_write_n & ~memory_read_n;
                        r_streak         <= '0;
                    end
                end
                BUS_ACCESS: begin
                    if (ram_done) begin
                        r_state     <= IDLE;
                        r_ram_read  <= 1'b0;
                        r_ram_write <= 1'b0;
                        if (r_ram_read) begin
                            r_bus_data_out <= ram_read_data;
                        end
                        // A strobe already released must not leave a stale served flag
                        if (w_bus_req) begin
                            r_bus_served <= 1'b1;
                        end
                    end
                end
                VIDEO_ACCESS: begin
                    if (ram_done) begin
                        r_state      <= IDLE;
                        r_ram_read   <= 1'b0;
                        r_ram_write  <= 1'b0;
                        r_video_data <= ram_read_data;
                        r_video_ack  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
